// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet II header inserter.
package eth_pkg;

    localparam int          ETH_HDR_BYTES  = 14;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        PAYLOAD,
        TAIL
    } state_t;

    // Illegal keep patterns are read as a full beat.
    function automatic logic [2:0] keep2cnt(input logic [3:0] keep);
        case (keep)
            4'b1000: return 3'd1;
            4'b1100: return 3'd2;
            4'b1110: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] cnt2keep(input logic [2:0] cnt);
        case (cnt)
            3'd1:    return 4'b1000;
            3'd2:    return 4'b1100;
            3'd3:    return 4'b1110;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [3:0] keep);
        return {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
    endfunction

endpackage

// File: rtl/eth_hdr_inserter.sv
// Prepends dst MAC, src MAC and EtherType to an IP/UDP byte stream,
// re-aligning payload by two bytes through a 16-bit carry register.
module eth_hdr_inserter
    import eth_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_IPV4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [47:0] mac_dest_i,
    input  logic [47:0] mac_src_i,
    input  logic [31:0] ip_udp_tdata_i,
    input  logic        ip_udp_tvld_i,
    input  logic        ip_udp_tlast_i,
    input  logic [3:0]  ip_udp_tkeep_i,
    output logic        ip_udp_rdy_o,
    output logic [31:0] eth_tdata_o,
    output logic        eth_tvld_o,
    output logic        eth_tlast_o,
    output logic [3:0]  eth_tkeep_o,
    input  logic        eth_rdy_i
);

    state_t      state;
    logic [47:0] dst_q;
    logic [47:0] src_q;
    logic [15:0] carry;
    logic [2:0]  tail_cnt;

    logic        load;
    logic        fire;
    logic [2:0]  in_cnt;
    logic [3:0]  pay_keep;
    logic [3:0]  tail_keep;

    assign load         = !eth_tvld_o || eth_rdy_i;
    assign ip_udp_rdy_o = (state == PAYLOAD) && load;
    assign fire         = ip_udp_rdy_o && ip_udp_tvld_i;

    always_comb begin
        in_cnt    = ip_udp_tlast_i ? keep2cnt(ip_udp_tkeep_i) : 3'd4;
        pay_keep  = (in_cnt <= 3'd2) ? cnt2keep(in_cnt + 3'd2) : 4'b1111;
        tail_keep = cnt2keep(tail_cnt - 3'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dst_q       <= '0;
            src_q       <= '0;
            carry       <= '0;
            tail_cnt    <= '0;
            eth_tdata_o <= '0;
            eth_tvld_o  <= 1'b0;
            eth_tlast_o <= 1'b0;
            eth_tkeep_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        eth_tvld_o  <= 1'b0;
                        eth_tlast_o <= 1'b0;
                    end
                    if (ip_udp_tvld_i) begin
                        dst_q <= mac_dest_i;
                        src_q <= mac_src_i;
                        state <= HDR0;
                    end
                end
                HDR0: begin
                    if (load) begin
                        eth_tdata_o <= dst_q[47:16];
                        eth_tkeep_o <= 4'b1111;
                        eth_tlast_o <= 1'b0;
                        eth_tvld_o  <= 1'b1;
                        state       <= HDR1;
                    end
                end
                HDR1: begin
                    if (load) begin
                        eth_tdata_o <= {dst_q[15:0], src_q[47:32]};
                        eth_tkeep_o <= 4'b1111;
                        eth_tlast_o <= 1'b0;
                        eth_tvld_o  <= 1'b1;
                        state       <= HDR2;
                    end
                end
                HDR2: begin
                    if (load) begin
                        eth_tdata_o <= src_q[31:0];
                        eth_tkeep_o <= 4'b1111;
                        eth_tlast_o <= 1'b0;
                        eth_tvld_o  <= 1'b1;
                        carry       <= ETHERTYPE;
                        state       <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (load) begin
                        // No input beat means an output bubble.
                        eth_tvld_o <= fire;
                        if (fire) begin
                            eth_tdata_o <= {carry, ip_udp_tdata_i[31:16]}
                                           & keep_mask(pay_keep);
                            eth_tkeep_o <= pay_keep;
                            carry       <= ip_udp_tdata_i[15:0];
                            if (ip_udp_tlast_i && in_cnt <= 3'd2) begin
                                eth_tlast_o <= 1'b1;
                                state       <= IDLE;
                            end else if (ip_udp_tlast_i) begin
                                eth_tlast_o <= 1'b0;
                                tail_cnt    <= in_cnt;
                                state       <= TAIL;
                            end else begin
                                eth_tlast_o <= 1'b0;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (load) begin
                        eth_tdata_o <= {carry, 16'h0} & keep_mask(tail_keep);
                        eth_tkeep_o <= tail_keep;
                        eth_tlast_o <= 1'b1;
                        eth_tvld_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_hdr_inserter.sv
// Self-checking bench: fixed vectors, corner sequences and a randomized
// run against a byte-level frame model.
module tb_eth_hdr_inserter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] mac_dest_i;
    logic [47:0] mac_src_i;
    logic [31:0] ip_udp_tdata_i;
    logic        ip_udp_tvld_i;
    logic        ip_udp_tlast_i;
    logic [3:0]  ip_udp_tkeep_i;
    logic        ip_udp_rdy_o;
    logic [31:0] eth_tdata_o;
    logic        eth_tvld_o;
    logic        eth_tlast_o;
    logic [3:0]  eth_tkeep_o;
    logic        eth_rdy_i;

    eth_hdr_inserter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mac_dest_i     (mac_dest_i),
        .mac_src_i      (mac_src_i),
        .ip_udp_tdata_i (ip_udp_tdata_i),
        .ip_udp_tvld_i  (ip_udp_tvld_i),
        .ip_udp_tlast_i (ip_udp_tlast_i),
        .ip_udp_tkeep_i (ip_udp_tkeep_i),
        .ip_udp_rdy_o   (ip_udp_rdy_o),
        .eth_tdata_o    (eth_tdata_o),
        .eth_tvld_o     (eth_tvld_o),
        .eth_tlast_o    (eth_tlast_o),
        .eth_tkeep_o    (eth_tkeep_o),
        .eth_rdy_i      (eth_rdy_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic [47:0] dst;
        logic [47:0] src;
    } beat_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        int          n_in;
        logic [31:0] in_d[3];
        logic [3:0]  lk;
        int          n_out;
        logic [31:0] out_d[7];
        logic [3:0]  out_lk;
    } vec_t;

    beat_t in_q[$];
    beat_t exp_q[$];
    bit    rdy_q[$];
    vec_t  vt[5];

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    last_cyc = 0;
    bit    vrand = 0;
    bit    rrand = 0;
    bit    vld_on = 0;
    bit    prev_stall = 0;
    bit    gap_chk = 0;
    bit    after_last = 0;
    beat_t prev_out;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] keep_of(input int n);
        if (n >= 4) return 4'b1111;
        if (n == 3) return 4'b1110;
        if (n == 2) return 4'b1100;
        return 4'b1000;
    endfunction

    // Frame model: header bytes followed by payload bytes, cut into
    // 4-byte beats, zero padded, keep set from the byte count.
    task automatic add_pkt(input logic [47:0] dst, input logic [47:0] src,
                           input logic [7:0] pl[$], input logic [3:0] kov);
        int          n;
        int          beats;
        int          nb;
        logic [7:0]  fr[$];
        beat_t       x;
        n = pl.size();
        beats = (n + 3) / 4;
        for (int b = 0; b < beats; b++) begin
            x.d   = $urandom;
            x.k   = 4'b1111;
            x.l   = (b == beats - 1);
            x.dst = dst;
            x.src = src;
            for (int j = 0; j < 4; j++)
                if (b * 4 + j < n) x.d[31 - 8 * j -: 8] = pl[b * 4 + j];
            if (x.l) x.k = (kov != 4'd0) ? kov : keep_of(n - 4 * b);
            in_q.push_back(x);
        end
        for (int i = 0; i < 6; i++) fr.push_back(dst[47 - 8 * i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(src[47 - 8 * i -: 8]);
        fr.push_back(8'h08);
        fr.push_back(8'h00);
        for (int i = 0; i < n; i++) fr.push_back(pl[i]);
        nb = fr.size();
        beats = (nb + 3) / 4;
        for (int b = 0; b < beats; b++) begin
            x.d = '0;
            for (int j = 0; j < 4; j++)
                if (b * 4 + j < nb) x.d[31 - 8 * j -: 8] = fr[b * 4 + j];
            x.k = keep_of(nb - 4 * b);
            x.l = (b == beats - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic step();
        beat_t e;
        if (in_q.size() > 0) begin
            if (!vld_on) vld_on = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
            ip_udp_tdata_i = in_q[0].d;
            ip_udp_tkeep_i = in_q[0].k;
            ip_udp_tlast_i = in_q[0].l;
            mac_dest_i     = in_q[0].dst;
            mac_src_i      = in_q[0].src;
        end else begin
            vld_on         = 1'b0;
            ip_udp_tdata_i = '0;
            ip_udp_tkeep_i = '0;
            ip_udp_tlast_i = 1'b0;
        end
        ip_udp_tvld_i = vld_on;
        if (rdy_q.size() > 0) eth_rdy_i = rdy_q.pop_front();
        else eth_rdy_i = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        cyc++;
        if (prev_stall)
            chk("hold", {eth_tvld_o, eth_tlast_o, eth_tkeep_o, eth_tdata_o},
                {1'b1, prev_out.l, prev_out.k, prev_out.d});
        if (eth_tvld_o && !eth_rdy_i) chk("in_rdy_stall", 64'(ip_udp_rdy_o), 0);
        prev_stall = eth_tvld_o && !eth_rdy_i;
        prev_out.d = eth_tdata_o;
        prev_out.k = eth_tkeep_o;
        prev_out.l = eth_tlast_o;
        if (eth_tvld_o && eth_rdy_i) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", {eth_tlast_o, eth_tkeep_o, eth_tdata_o}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {eth_tlast_o, eth_tkeep_o, eth_tdata_o},
                    {e.l, e.k, e.d});
            end
            if (gap_chk && after_last) chk("idle_gap", 64'(cyc - last_cyc), 2);
            after_last = eth_tlast_o;
            if (eth_tlast_o) last_cyc = cyc;
        end
        if (ip_udp_tvld_i && ip_udp_rdy_o) begin
            void'(in_q.pop_front());
            vld_on = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 64'(exp_q.size() + in_q.size()), 0);
        in_q.delete();
        exp_q.delete();
        repeat (4) step();
    endtask

    task automatic apply_vec(input int v);
        beat_t x;
        for (int i = 0; i < vt[v].n_in; i++) begin
            x.d   = vt[v].in_d[i];
            x.l   = (i == vt[v].n_in - 1);
            x.k   = x.l ? vt[v].lk : 4'b1111;
            x.dst = vt[v].dst;
            x.src = vt[v].src;
            in_q.push_back(x);
        end
        for (int i = 0; i < vt[v].n_out; i++) begin
            x.d = vt[v].out_d[i];
            x.l = (i == vt[v].n_out - 1);
            x.k = x.l ? vt[v].out_lk : 4'b1111;
            exp_q.push_back(x);
        end
        drain(200);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [3:0] bad_keeps[5];
        logic [47:0] d1;
        logic [47:0] s1;
        int          len;
        logic [3:0]  kov;

        d1 = 48'h112233445566;
        s1 = 48'hAABBCCDDEEFF;
        bad_keeps[0] = 4'b1010;
        bad_keeps[1] = 4'b0001;
        bad_keeps[2] = 4'b0111;
        bad_keeps[3] = 4'b0000;
        bad_keeps[4] = 4'b0011;

        for (int v = 0; v < 5; v++) begin
            vt[v].dst      = d1;
            vt[v].src      = s1;
            vt[v].out_d[0] = 32'h11223344;
            vt[v].out_d[1] = 32'h5566AABB;
            vt[v].out_d[2] = 32'hCCDDEEFF;
        end
        vt[0].n_in = 2; vt[0].in_d[0] = 32'h45000030; vt[0].in_d[1] = 32'h12345678;
        vt[0].lk = 4'b1111; vt[0].n_out = 6; vt[0].out_lk = 4'b1100;
        vt[0].out_d[3] = 32'h08004500; vt[0].out_d[4] = 32'h00301234;
        vt[0].out_d[5] = 32'h56780000;
        vt[1].n_in = 1; vt[1].in_d[0] = 32'hDEADBEEF; vt[1].lk = 4'b1000;
        vt[1].n_out = 4; vt[1].out_lk = 4'b1110; vt[1].out_d[3] = 32'h0800DE00;
        vt[2].n_in = 2; vt[2].in_d[0] = 32'hA1A2A3A4; vt[2].in_d[1] = 32'hB1B2B3FF;
        vt[2].lk = 4'b1110; vt[2].n_out = 6; vt[2].out_lk = 4'b1000;
        vt[2].out_d[3] = 32'h0800A1A2; vt[2].out_d[4] = 32'hA3A4B1B2;
        vt[2].out_d[5] = 32'hB3000000;
        vt[3].n_in = 1; vt[3].in_d[0] = 32'hCAFEF00D; vt[3].lk = 4'b1100;
        vt[3].n_out = 4; vt[3].out_lk = 4'b1111; vt[3].out_d[3] = 32'h0800CAFE;
        vt[4].n_in = 1; vt[4].in_d[0] = 32'h01020304; vt[4].lk = 4'b1010;
        vt[4].n_out = 5; vt[4].out_lk = 4'b1100;
        vt[4].out_d[3] = 32'h08000102; vt[4].out_d[4] = 32'h03040000;

        reset_n = 1'b0;
        mac_dest_i = '0;
        mac_src_i = '0;
        ip_udp_tdata_i = '0;
        ip_udp_tvld_i = 1'b0;
        ip_udp_tlast_i = 1'b0;
        ip_udp_tkeep_i = '0;
        eth_rdy_i = 1'b1;
        #12;
        chk("rst_tvld", 64'(eth_tvld_o), 0);
        chk("rst_tlast", 64'(eth_tlast_o), 0);
        chk("rst_tdata", 64'(eth_tdata_o), 0);
        chk("rst_tkeep", 64'(eth_tkeep_o), 0);
        chk("rst_rdy", 64'(ip_udp_rdy_o), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) apply_vec(v);

        // Output stall during HDR1, then alternating ready.
        rdy_q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        apply_vec(0);
        rdy_q.delete();

        // Back-to-back frames with different MACs.
        gap_chk = 1'b1;
        after_last = 1'b0;
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        add_pkt(d1, s1, pl, 4'd0);
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'($urandom));
        add_pkt(48'h0A0B0C0D0E0F, 48'h102030405060, pl, 4'd0);
        drain(200);
        gap_chk = 1'b0;

        // Reset in the middle of the payload.
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
        add_pkt(d1, s1, pl, 4'd0);
        repeat (6) step();
        chk("pre_rst_vld", 64'(eth_tvld_o), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tvld", 64'(eth_tvld_o), 0);
        chk("mid_rst_rdy", 64'(ip_udp_rdy_o), 0);
        chk("mid_rst_tlast", 64'(eth_tlast_o), 0);
        in_q.delete();
        exp_q.delete();
        vld_on = 1'b0;
        prev_stall = 1'b0;
        after_last = 1'b0;
        ip_udp_tvld_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply_vec(2);

        // Randomized traffic with random valid and ready.
        vrand = 1'b1;
        rrand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            pl.delete();
            kov = 4'd0;
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 7) == 0) begin
                len = ((len + 3) / 4) * 4;
                kov = bad_keeps[$urandom_range(0, 4)];
            end
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            add_pkt({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)},
                    pl, kov);
        end
        drain(20000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
